// File: rtl/prirv32_pkg.sv
// rtl/prirv32_pkg.sv - shared encodings, FSM states and defaults for the load/store unit
package prirv32_pkg;

    localparam int LSU_XLEN        = 32;
    localparam int LSU_BUS_TIMEOUT = 255;

    localparam logic [1:0] LSU_SIZE_B = 2'b00;
    localparam logic [1:0] LSU_SIZE_H = 2'b01;
    localparam logic [1:0] LSU_SIZE_W = 2'b10;
    localparam logic [1:0] LSU_SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_BUS  = 2'd1,
        LSU_RESP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/prirv32_lsu_if.sv
// rtl/prirv32_lsu_if.sv - word-wide valid/ready data bus between the LSU and memory
interface prirv32_lsu_if;
    import prirv32_pkg::*;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [LSU_XLEN-1:0]   mem_addr;
    logic [3:0]            mem_wstrb;
    logic [LSU_XLEN-1:0]   mem_wdata;
    logic [LSU_XLEN-1:0]   mem_rdata;

    modport master (
        output mem_valid, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wstrb, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/prirv32_lsu_align.sv
// rtl/prirv32_lsu_align.sv - store lane steering, strobes, misalignment detect and load extension
module prirv32_lsu_align
    import prirv32_pkg::*;
(
    input  logic        st_is_store_i,
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [31:0] st_lanes_o,
    output logic [3:0]  st_wstrb_o,
    output logic        st_misaligned_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_misaligned_o = 1'b0;
        st_lanes_o      = st_wdata_i;
        st_wstrb_o      = 4'b0000;
        case (st_size_i)
            LSU_SIZE_B: begin
                st_lanes_o = {4{st_wdata_i[7:0]}};
                st_wstrb_o = 4'b0001 << st_off_i;
            end
            LSU_SIZE_H: begin
                st_misaligned_o = st_off_i[0];
                st_lanes_o      = {2{st_wdata_i[15:0]}};
                st_wstrb_o      = 4'b0011 << st_off_i;
            end
            LSU_SIZE_W: begin
                st_misaligned_o = (st_off_i != 2'b00);
                st_wstrb_o      = 4'b1111;
            end
            default: st_misaligned_o = 1'b1;
        endcase
        if (!st_is_store_i || st_misaligned_o) begin
            st_wstrb_o = 4'b0000;
        end
    end

    // Halves are only ever extracted at offset 0 or 2, so off[0] does not steer them.
    assign ld_byte = ld_rdata_i[{ld_off_i, 3'b000} +: 8];
    assign ld_half = ld_rdata_i[{ld_off_i[1], 4'b0000} +: 16];

    always_comb begin
        ld_data_o = ld_rdata_i;
        case (ld_size_i)
            LSU_SIZE_B: ld_data_o = {{24{ld_byte[7]  & ~ld_unsigned_i}}, ld_byte};
            LSU_SIZE_H: ld_data_o = {{16{ld_half[15] & ~ld_unsigned_i}}, ld_half};
            default:    ld_data_o = ld_rdata_i;
        endcase
    end

endmodule

// File: rtl/prirv32_lsu.sv
// rtl/prirv32_lsu.sv - load/store unit: request latch, bus transaction FSM with timeout, writeback response
module prirv32_lsu
    import prirv32_pkg::*;
#(
    parameter int BUS_TIMEOUT = LSU_BUS_TIMEOUT,
    parameter int XLEN        = LSU_XLEN
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_is_store_i,
    input  logic [1:0]       req_size_i,
    input  logic             req_unsigned_i,
    input  logic [XLEN-1:0]  req_addr_i,
    input  logic [XLEN-1:0]  req_wdata_i,
    input  logic [4:0]       req_rd_i,
    prirv32_lsu_if.master    mem,
    output logic             resp_valid_o,
    output logic [4:0]       resp_rd_o,
    output logic [XLEN-1:0]  resp_rdata_o,
    output logic             resp_misaligned_o,
    output logic             resp_fault_o
);

    localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] STALL_LIMIT = CW'(BUS_TIMEOUT);

    lsu_state_e      state_q;
    logic            is_store_q;
    logic [1:0]      size_q;
    logic [1:0]      off_q;
    logic            unsigned_q;
    logic [4:0]      rd_q;
    logic [CW-1:0]   stall_q;
    logic [CW-1:0]   stall_d;
    logic            timeout_d;

    logic            mem_valid_q;
    logic [XLEN-1:0] mem_addr_q;
    logic [3:0]      mem_wstrb_q;
    logic [XLEN-1:0] mem_wdata_q;
    logic            resp_valid_q;
    logic [4:0]      resp_rd_q;
    logic [XLEN-1:0] resp_rdata_q;
    logic            resp_misaligned_q;
    logic            resp_fault_q;

    logic [31:0]     st_lanes;
    logic [3:0]      st_wstrb;
    logic            st_misaligned;
    logic [31:0]     ld_data;

    prirv32_lsu_align u_align (
        .st_is_store_i   (req_is_store_i),
        .st_size_i       (req_size_i),
        .st_off_i        (req_addr_i[1:0]),
        .st_wdata_i      (req_wdata_i),
        .st_lanes_o      (st_lanes),
        .st_wstrb_o      (st_wstrb),
        .st_misaligned_o (st_misaligned),
        .ld_size_i       (size_q),
        .ld_off_i        (off_q),
        .ld_unsigned_i   (unsigned_q),
        .ld_rdata_i      (mem.mem_rdata),
        .ld_data_o       (ld_data)
    );

    assign stall_d   = stall_q + 1'b1;
    assign timeout_d = (BUS_TIMEOUT != 0) && (stall_d == STALL_LIMIT);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= LSU_IDLE;
            is_store_q        <= 1'b0;
            size_q            <= LSU_SIZE_B;
            off_q             <= 2'b00;
            unsigned_q        <= 1'b0;
            rd_q              <= '0;
            stall_q           <= '0;
            mem_valid_q       <= 1'b0;
            mem_addr_q        <= '0;
            mem_wstrb_q       <= '0;
            mem_wdata_q       <= '0;
            resp_valid_q      <= 1'b0;
            resp_rd_q         <= '0;
            resp_rdata_q      <= '0;
            resp_misaligned_q <= 1'b0;
            resp_fault_q      <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (req_valid_i) begin
                        is_store_q <= req_is_store_i;
                        size_q     <= req_size_i;
                        off_q      <= req_addr_i[1:0];
                        unsigned_q <= req_unsigned_i;
                        rd_q       <= req_is_store_i ? 5'd0 : req_rd_i;
                        stall_q    <= '0;
                        if (st_misaligned) begin
                            state_q           <= LSU_RESP;
                            resp_valid_q      <= 1'b1;
                            resp_misaligned_q <= 1'b1;
                            resp_rd_q         <= req_is_store_i ? 5'd0 : req_rd_i;
                            resp_rdata_q      <= '0;
                        end else begin
                            state_q     <= LSU_BUS;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {req_addr_i[XLEN-1:2], 2'b00};
                            mem_wstrb_q <= st_wstrb;
                            mem_wdata_q <= req_is_store_i ? st_lanes : '0;
                        end
                    end
                end
                LSU_BUS: begin
                    // A completing handshake wins over a timeout reached in the same cycle.
                    if (mem.mem_ready || timeout_d) begin
                        state_q      <= LSU_RESP;
                        mem_valid_q  <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_wstrb_q  <= '0;
                        mem_wdata_q  <= '0;
                        resp_valid_q <= 1'b1;
                        resp_rd_q    <= rd_q;
                        resp_fault_q <= !mem.mem_ready;
                        resp_rdata_q <= (mem.mem_ready && !is_store_q) ? ld_data : '0;
                    end else begin
                        stall_q <= stall_d;
                    end
                end
                LSU_RESP: begin
                    state_q           <= LSU_IDLE;
                    resp_valid_q      <= 1'b0;
                    resp_rd_q         <= '0;
                    resp_rdata_q      <= '0;
                    resp_misaligned_q <= 1'b0;
                    resp_fault_q      <= 1'b0;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    assign req_ready_o       = (state_q == LSU_IDLE);
    assign mem.mem_valid     = mem_valid_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wstrb     = mem_wstrb_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign resp_valid_o      = resp_valid_q;
    assign resp_rd_o         = resp_rd_q;
    assign resp_rdata_o      = resp_rdata_q;
    assign resp_misaligned_o = resp_misaligned_q;
    assign resp_fault_o      = resp_fault_q;

endmodule

// File: tb/tb_prirv32_lsu.sv
// tb/tb_prirv32_lsu.sv - directed vector bench for prirv32_lsu
module tb_prirv32_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;

    int checks;
    int errors;

    prirv32_lsu_if bus();

    prirv32_lsu #(.BUS_TIMEOUT(4), .XLEN(32)) dut (
        .clk_i             (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_is_store_i    (req_is_store),
        .req_size_i        (req_size),
        .req_unsigned_i    (req_unsigned),
        .req_addr_i        (req_addr),
        .req_wdata_i       (req_wdata),
        .req_rd_i          (req_rd),
        .mem               (bus),
        .resp_valid_o      (resp_valid),
        .resp_rd_o         (resp_rd),
        .resp_rdata_o      (resp_rdata),
        .resp_misaligned_o (resp_misaligned),
        .resp_fault_o      (resp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
        req_is_store = st;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_rd       = rd;
        req_valid    = 1'b1;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vt[i];
        @(negedge clk);
        chk($sformatf("v%0d_ready_idle", i), {31'd0, req_ready}, 32'd1);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = v.rdata;
        drive_req(v.st, v.sz, v.uns, v.addr, v.wdata, v.rd);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.mis) begin
            chk($sformatf("v%0d_mis_resp_valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("v%0d_mis_flag", i), {31'd0, resp_misaligned}, 32'd1);
            chk($sformatf("v%0d_mis_no_bus", i), {31'd0, bus.mem_valid}, 32'd0);
            chk($sformatf("v%0d_mis_rd", i), {27'd0, resp_rd}, {27'd0, v.e_rd});
            chk($sformatf("v%0d_mis_rdata", i), resp_rdata, 32'd0);
        end else begin
            chk($sformatf("v%0d_mem_valid", i), {31'd0, bus.mem_valid}, 32'd1);
            chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, v.e_addr);
            chk($sformatf("v%0d_mem_wstrb", i), {28'd0, bus.mem_wstrb}, {28'd0, v.e_wstrb});
            if (v.st) chk($sformatf("v%0d_mem_wdata", i), bus.mem_wdata, v.e_wdata);
            chk($sformatf("v%0d_resp_early", i), {31'd0, resp_valid}, 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_resp_valid", i), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("v%0d_resp_rd", i), {27'd0, resp_rd}, {27'd0, v.e_rd});
            chk($sformatf("v%0d_resp_rdata", i), resp_rdata, v.e_rdata);
            chk($sformatf("v%0d_resp_flags", i), {30'd0, resp_misaligned, resp_fault}, 32'd0);
            chk($sformatf("v%0d_bus_idle", i), {31'd0, bus.mem_valid}, 32'd0);
        end
        @(posedge clk); #1;
        chk($sformatf("v%0d_resp_pulse", i), {31'd0, resp_valid}, 32'd0);
        chk($sformatf("v%0d_ready_back", i), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_is_store  = 1'b0;
        req_size      = 2'b00;
        req_unsigned  = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_rd        = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        //          st  sz     uns addr          wdata         rd     rdata         mis e_addr        e_wstrb  e_wdata       e_rdata       e_rd
        vt[0]  = '{1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00A5, 5'd7,  32'h0,         1'b0, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 32'h0,         5'd0};
        vt[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_2001, 32'h0,         5'd5,  32'h0000_80FF, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'hFFFF_FF80, 5'd5};
        vt[2]  = '{1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0,         5'd6,  32'h0000_80FF, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'h0000_0080, 5'd6};
        vt[3]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,         5'd8,  32'h8001_1234, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'hFFFF_8001, 5'd8};
        vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h0000_2006, 32'h0,         5'd9,  32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0,         5'd9};
        vt[5]  = '{1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h1234_BEEF, 5'd4,  32'h0,         1'b0, 32'h0000_3000, 4'b1100, 32'hBEEF_BEEF, 32'h0,         5'd0};
        vt[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'hDEAD_BEEF, 5'd2,  32'h0,         1'b0, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0,         5'd0};
        vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h0000_2000, 32'h0,         5'd12, 32'h1234_F00D, 1'b0, 32'h0000_2000, 4'b0000, 32'h0,         32'h0000_F00D, 5'd12};
        vt[8]  = '{1'b0, 2'b01, 1'b0, 32'h0000_2001, 32'h0,         5'd13, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0,         5'd13};
        vt[9]  = '{1'b0, 2'b11, 1'b0, 32'h0000_5000, 32'h0,         5'd14, 32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0,         5'd14};
        vt[10] = '{1'b0, 2'b10, 1'b1, 32'h0000_2004, 32'h0,         5'd31, 32'hCAFE_BABE, 1'b0, 32'h0000_2004, 4'b0000, 32'h0,         32'hCAFE_BABE, 5'd31};
        vt[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0010, 32'h1234_5677, 5'd1,  32'h0,         1'b0, 32'h0000_0010, 4'b0001, 32'h7777_7777, 32'h0,         5'd0};
        vt[12] = '{1'b1, 2'b01, 1'b0, 32'h0000_3001, 32'h0000_FFFF, 5'd3,  32'h0,         1'b1, 32'h0,         4'b0000, 32'h0,         32'h0,         5'd0};
        vt[13] = '{1'b0, 2'b00, 1'b0, 32'h0000_200F, 32'h0,         5'd20, 32'h7F00_0000, 1'b0, 32'h0000_200C, 4'b0000, 32'h0,         32'h0000_007F, 5'd20};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wstrb", {28'd0, bus.mem_wstrb}, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_resp", {25'd0, resp_valid, resp_rd, resp_misaligned, resp_fault}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_vec(i);

        // Three wait states: address/strobe held, response five cycles after accept.
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h1122_3344;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_6008, 32'h0, 5'd3);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            if (lat <= 4) begin
                chk($sformatf("ws_mem_valid_c%0d", lat), {31'd0, bus.mem_valid}, 32'd1);
                chk($sformatf("ws_mem_addr_c%0d", lat), bus.mem_addr, 32'h0000_6008);
                chk($sformatf("ws_mem_wstrb_c%0d", lat), {28'd0, bus.mem_wstrb}, 32'd0);
            end
            if (lat == 4) bus.mem_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk("ws_latency", lat, 32'd5);
        chk("ws_rdata", resp_rdata, 32'h1122_3344);
        chk("ws_rd", {27'd0, resp_rd}, 32'd3);
        chk("ws_fault", {31'd0, resp_fault}, 32'd0);
        @(posedge clk); #1;

        // Bus never ready: timeout after four stall cycles.
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_7000, 32'h0, 5'd17);
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("to_latency", lat, 32'd5);
        chk("to_fault", {31'd0, resp_fault}, 32'd1);
        chk("to_rdata", resp_rdata, 32'd0);
        chk("to_mis", {31'd0, resp_misaligned}, 32'd0);
        chk("to_bus_dropped", {31'd0, bus.mem_valid}, 32'd0);
        @(posedge clk); #1;
        chk("to_ready_back", {31'd0, req_ready}, 32'd1);

        // Reset mid-BUS drops the bus request without a clock edge.
        @(negedge clk);
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_8000, 32'h0, 5'd21);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rb_mem_valid_pre", {31'd0, bus.mem_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_mem_valid_async", {31'd0, bus.mem_valid}, 32'd0);
        chk("rb_ready_async", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rb_no_resp_c%0d", k), {31'd0, resp_valid}, 32'd0);
            chk($sformatf("rb_ready_c%0d", k), {31'd0, req_ready}, 32'd1);
        end

        // Back-to-back: valid held, second op accepted on the first IDLE cycle.
        @(negedge clk);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0000_80FF;
        drive_req(1'b0, 2'b00, 1'b1, 32'h0000_2001, 32'h0, 5'd10);
        @(posedge clk); #1;
        drive_req(1'b0, 2'b10, 1'b0, 32'h0000_2008, 32'h0, 5'd11);
        chk("bb_c1_ready", {31'd0, req_ready}, 32'd0);
        chk("bb_c1_addr", bus.mem_addr, 32'h0000_2000);
        @(posedge clk); #1;
        chk("bb_c2_resp", {31'd0, resp_valid}, 32'd1);
        chk("bb_c2_rd", {27'd0, resp_rd}, 32'd10);
        chk("bb_c2_rdata", resp_rdata, 32'h0000_0080);
        chk("bb_c2_ready", {31'd0, req_ready}, 32'd0);
        bus.mem_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1;
        chk("bb_c3_ready", {31'd0, req_ready}, 32'd1);
        chk("bb_c3_resp", {31'd0, resp_valid}, 32'd0);
        chk("bb_c3_mem_valid", {31'd0, bus.mem_valid}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("bb_c4_mem_valid", {31'd0, bus.mem_valid}, 32'd1);
        chk("bb_c4_addr", bus.mem_addr, 32'h0000_2008);
        @(posedge clk); #1;
        chk("bb_c5_resp", {31'd0, resp_valid}, 32'd1);
        chk("bb_c5_rd", {27'd0, resp_rd}, 32'd11);
        chk("bb_c5_rdata", resp_rdata, 32'h0BAD_F00D);
        @(posedge clk); #1;
        chk("bb_c6_idle", {30'd0, resp_valid, req_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prirv32_lsu.md
Name: prirv32_lsu

Overview:
- Load/store unit directly downstream of the execute unit.
- Accepts one memory operation per handshake from the execute unit: effective address, store data, size, signedness and destination register.
- Checks alignment, steers byte lanes and write strobes, and runs a valid/ready transaction on the word-wide data bus.
- Returns a one-cycle response with the sign/zero-extended load result or a store completion, for writeback.

Parameters:
- BUS_TIMEOUT, 255: stall cycles tolerated in BUS before the transaction is aborted with a fault; 0 disables the timeout.
- XLEN, 32: data/address width; only 32 is supported.

Ports:
- clk_i  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  1  execute unit presents a memory op
- req_ready_o  output  1  LSU can accept a request (high only in IDLE)
- req_is_store_i  input  1  1 = store, 0 = load
- req_size_i  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  input  1  1 = zero-extend load (lbu/lhu)
- req_addr_i  input  32  effective byte address (rs1 + imm)
- req_wdata_i  input  32  store data (rs2 value), right-justified
- req_rd_i  input  5  destination register index
- mem_valid_o  output  1  bus request
- mem_ready_i  input  1  bus accepts/completes in the same cycle
- mem_addr_o  output  32  word-aligned address, addr[1:0] = 0
- mem_wstrb_o  output  4  byte write enables; 0000 for loads
- mem_wdata_o  output  32  lane-replicated store data
- mem_rdata_i  input  32  read data, valid when mem_valid_o and mem_ready_i are both high
- resp_valid_o  output  1  one-cycle response pulse
- resp_rd_o  output  5  latched rd; forced to 0 for stores
- resp_rdata_o  output  32  extended load data; 0 for stores and errors
- resp_misaligned_o  output  1  address misaligned or size 11; no bus access made
- resp_fault_o  output  1  bus timeout

Behaviour:
- Reset values:
  - state IDLE; req_ready_o = 1.
  - All other outputs 0: mem_valid_o, mem_addr_o, mem_wstrb_o, mem_wdata_o, resp_*.
  - Reset asserted mid-transaction drops mem_valid_o immediately; the operation is lost and no response is issued.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch all req_* fields.
  - Misaligned request goes to RESP with resp_misaligned_o = 1. Misaligned means: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
  - Any other request goes to BUS.
- BUS:
  - mem_valid_o = 1. mem_addr_o, mem_wstrb_o and mem_wdata_o are held stable until mem_ready_i.
  - On mem_ready_i, capture and extend mem_rdata_i, then go to RESP.
  - The stall counter increments on each cycle with mem_ready_i low.
  - When the counter reaches BUS_TIMEOUT (if non-zero), go to RESP with resp_fault_o = 1.
  - mem_ready_i in the same cycle as the counter reaching the limit takes priority: normal completion, no fault.
- RESP: resp_valid_o = 1 for exactly one cycle, then IDLE. A new request is accepted on the first IDLE cycle.
- Latency from accept edge N:
  - Zero-wait bus: mem_valid_o high at N+1, resp_valid_o high at N+2.
  - Each wait state adds one cycle.
  - Misaligned request: resp_valid_o high at N+1.
- Store lane rules, with off = addr[1:0]:
  - byte: wdata = {4{b[7:0]}}, wstrb = 0001 << off.
  - half: wdata = {2{h[15:0]}}, wstrb = 0011 << off.
  - word: wstrb = 1111.
- Load extraction:
  - byte: mem_rdata_i[8*off +: 8].
  - half: mem_rdata_i[8*off +: 16].
  - Sign-extended unless req_unsigned_i = 1.
  - word: passed through; req_unsigned_i is ignored.
- Throughput: at most one outstanding transaction. req_ready_o is low in BUS and RESP.

Decomposition:
- prirv32_pkg holds:
  - size encodings LSU_SIZE_B/H/W/X;
  - FSM state enum;
  - default BUS_TIMEOUT.
- Sub-module prirv32_lsu_align: purely combinational store lane steering, strobe generation, load extraction/extension and misalignment detect. The top level holds the FSM, latches and timeout counter.

Test Plan:
- sb addr 0x1003, wdata 0x000000A5, zero-wait -> mem_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5; resp at N+2 with rd 0, rdata 0.
- lb addr 0x2001, mem_rdata 0x0000_80FF, unsigned 0 -> resp_rdata 0xFFFFFF80. Same with lbu -> 0x00000080.
- lh addr 0x2002, mem_rdata 0x8001_1234 -> 0xFFFF8001. lw addr 0x2006 -> misaligned resp at N+1, mem_valid_o never asserted.
- lw with mem_ready_i held low 3 cycles -> mem_addr/wstrb stable, resp at N+5 with correct data. BUS_TIMEOUT = 4 with ready never high -> resp_fault_o = 1, rdata 0.
- rst_n low while in BUS -> mem_valid_o low without waiting for a clock edge; after release req_ready_o = 1 and no stray resp_valid_o.
- Back-to-back requests held valid -> second accepted on the cycle after RESP; responses are in order with correct rd.
